// File: rtl/reg_file.sv
// 32 x W register file: two combinational datapath read ports, one debug read port, one write port.
// Optional write-through bypass on RD1/RD2 is compiled in with `define REGFILE_BYPASS_EN.
module reg_file #(
   parameter int W = 32,
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         RegWrite,
   input  logic [4:0]   A1,
   input  logic [4:0]   A2,
   input  logic [4:0]   A3,
   input  logic [W-1:0] WD3,
   output logic [W-1:0] RD1,
   output logic [W-1:0] RD2,
   input  logic [4:0]   dbg_addr,
   output logic [W-1:0] dbg_data
);

   logic [W-1:0] regs_q [N];
   logic         wr_en;

   assign wr_en = rst_n && RegWrite && (A3 != 5'd0);

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[A3] <= WD3;
      end
   end

   function automatic logic [W-1:0] stored(input logic [4:0] addr);
      return (addr == 5'd0) ? '0 : regs_q[addr];
   endfunction

   always_comb begin
      RD1      = stored(A1);
      RD2      = stored(A2);
      dbg_data = stored(dbg_addr);
`ifdef REGFILE_BYPASS_EN
      // wr_en already excludes A3 == 0, so a bypass can never expose a write to r0.
      if (wr_en && (A3 == A1)) RD1 = WD3;
      if (wr_en && (A3 == A2)) RD2 = WD3;
`endif
   end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random traffic against an array model.
// Expectations follow REGFILE_BYPASS_EN when the bench is compiled with it.
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RegWrite;
   logic [4:0]  A1, A2, A3, dbg_addr;
   logic [31:0] WD3, RD1, RD2, dbg_data;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [31:0] mem [32];

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   reg_file #(.W(32), .N(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .RegWrite (RegWrite),
      .A1       (A1),
      .A2       (A2),
      .A3       (A3),
      .WD3      (WD3),
      .RD1      (RD1),
      .RD2      (RD2),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference read: r0 is zero, bypassable ports see a pending legal write.
   function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit bypassable);
      if (a == 5'd0) return 32'h0;
      if (bypassable && BYP && rst_n && RegWrite && (A3 == a)) return WD3;
      return mem[a];
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".rd1"}, RD1, exp_rd(A1, 1'b1));
      chk({tag, ".rd2"}, RD2, exp_rd(A2, 1'b1));
      chk({tag, ".dbg"}, dbg_data, exp_rd(dbg_addr, 1'b0));
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
   endtask

   // Rising edge with model update, then settle.
   task automatic step();
      @(posedge clk);
      if (rst_n && RegWrite && (A3 != 5'd0)) mem[A3] = WD3;
      #1;
   endtask

   initial begin
      logic [31:0] before_rd1, before_dbg;
      clear_model();
      rst_n = 1'b0; RegWrite = 1'b0; A3 = 5'd0; WD3 = 32'h0;
      A1 = 5'd5; A2 = 5'd31; dbg_addr = 5'd17;
      #3;
      chk("reset.rd1", RD1, 32'h0);
      chk("reset.rd2", RD2, 32'h0);
      chk("reset.dbg", dbg_data, 32'h0);

      // Write r5, then pulse reset between edges.
      @(negedge clk);
      rst_n = 1'b1; RegWrite = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF;
      step();
      RegWrite = 1'b0; A1 = 5'd5;
      #1 chk("r5.written", RD1, 32'hDEADBEEF);
      rst_n = 1'b0;
      #1 clear_model();
      chk("r5.async_clear", RD1, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic write and hold.
      RegWrite = 1'b1; A3 = 5'd8; WD3 = 32'h12345678; A1 = 5'd8;
      step();
      chk("r8.write", RD1, 32'h12345678);
      @(negedge clk);
      RegWrite = 1'b0; WD3 = 32'hFFFFFFFF;
      step();
      chk("r8.hold", RD1, 32'h12345678);

      // Register zero, including same-cycle read.
      @(negedge clk);
      RegWrite = 1'b1; A3 = 5'd0; WD3 = 32'hFFFFFFFF; A1 = 5'd0; A2 = 5'd0; dbg_addr = 5'd0;
      #1 chk("r0.same_cycle", RD1, 32'h0);
      step();
      chk("r0.rd1", RD1, 32'h0);
      chk("r0.rd2", RD2, 32'h0);
      chk("r0.dbg", dbg_data, 32'h0);

      // Same address on all read ports.
      @(negedge clk);
      A3 = 5'd3; WD3 = 32'hA5A5A5A5;
      step();
      RegWrite = 1'b0; A1 = 5'd3; A2 = 5'd3; dbg_addr = 5'd3;
      #1;
      chk("dual.rd1", RD1, 32'hA5A5A5A5);
      chk("dual.rd2", RD2, 32'hA5A5A5A5);
      chk("dual.dbg", dbg_data, 32'hA5A5A5A5);

      // Write/read hazard on r9.
      @(negedge clk);
      RegWrite = 1'b1; A3 = 5'd9; WD3 = 32'h1;
      step();
      @(negedge clk);
      A1 = 5'd9; dbg_addr = 5'd9; WD3 = 32'h2;
      #1;
      before_rd1 = BYP ? 32'h2 : 32'h1;
      before_dbg = 32'h1;
      chk("hazard.rd1_before", RD1, before_rd1);
      chk("hazard.dbg_before", dbg_data, before_dbg);
      step();
      chk("hazard.rd1_after", RD1, 32'h2);
      chk("hazard.dbg_after", dbg_data, 32'h2);

      // Sweep every register.
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         RegWrite = 1'b1; A3 = 5'(i); WD3 = i * 32'h01010101;
         step();
      end
      @(negedge clk);
      RegWrite = 1'b0;
      for (int a = 0; a < 32; a++) begin
         A1 = 5'(a); A2 = 5'(31 - a); dbg_addr = 5'(a);
         #1;
         chk("sweep.rd1", RD1, a * 32'h01010101);
         chk("sweep.rd2", RD2, (31 - a) * 32'h01010101);
         chk("sweep.dbg", dbg_data, a * 32'h01010101);
      end

      // Random traffic with biased address collisions and occasional reset.
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         rst_n    = ($urandom_range(0, 39) != 0);
         RegWrite = $urandom_range(0, 3) != 0;
         A3       = 5'($urandom_range(0, 31));
         A1       = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom_range(0, 31));
         A2       = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom_range(0, 31));
         dbg_addr = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom_range(0, 31));
         WD3      = $urandom;
         #1;
         if (!rst_n) clear_model();
         check_all("rand.pre");
         step();
         check_all("rand.post");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
